// File: rtl/seq_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding and
// helpers that derive the digit count and counter width from the
// operand geometry.
package seq_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

  // Number of DIGIT-bit slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so a single-digit
  // configuration still has a legal (constant-zero) counter.
  function automatic int calc_cnt_w(input int width, input int digit);
    int w;
    w = $clog2(width / digit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple adder assembled from per-bit full-adder
// equations; the sequential adder reuses one of these every cycle.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  // Ripple the carry through each bit position.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[DIGIT];
  end

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder: {c_out,sum} = a + b + c_in computed DIGIT bits per
// clock through a single reused ripple slice, with valid/ready handshakes
// on both sides.
// Optional build macro SEQ_ADDER_SUB_EN adds a 'sub' input selecting
// a + ~b + ~c_in (subtract with c_in as borrow-in, c_out = no-borrow).
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  int unsigned        off;
  logic [DIGIT-1:0]   x_d;
  logic [DIGIT-1:0]   y_d;
  logic [DIGIT-1:0]   s_d;
  logic               co_d;
  logic               last;
  logic               accept;
  logic [WIDTH-1:0]   b_eff;
  logic               ci_eff;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC) || (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_W'(NDIG - 1));

  // Subtraction is folded into the operands at accept time so the
  // arithmetic slice is identical in both modes.
`ifdef SEQ_ADDER_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = sub ? ~c_in : c_in;
`else
  assign b_eff  = b;
  assign ci_eff = c_in;
`endif

  assign off = 32'(cnt) * 32'(DIGIT);
  assign x_d = a_q[off +: DIGIT];
  assign y_d = b_q[off +: DIGIT];

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (x_d),
    .y  (y_d),
    .ci (carry_q),
    .s  (s_d),
    .co (co_d)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: accept in IDLE, finish on last digit, deliver in DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_CALC;
      S_CALC:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and one digit of addition per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= ci_eff;
      sum_q   <= '0;
      cnt     <= '0;
    end else if (state == S_CALC) begin
      sum_q[off +: DIGIT] <= s_d;
      carry_q             <= co_d;
      if (last) begin
        cout_q <= co_d;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;

endmodule
